// File: rtl/seg7_scan_driver_if.sv
// CPU-side register port of the 7-segment scan driver: write strobes, write data and readback.
interface seg7_scan_driver_if;
    logic        val_we_i;
    logic        mask_we_i;
    logic [31:0] wdata_i;
    logic [31:0] value_o;
    logic [7:0]  mask_o;

    modport slave (
        input  val_we_i,
        input  mask_we_i,
        input  wdata_i,
        output value_o,
        output mask_o
    );

    modport master (
        output val_we_i,
        output mask_we_i,
        output wdata_i,
        input  value_o,
        input  mask_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed hex display driver with a one-cycle blank slot between digits.
// Optional leading-zero suppression is enabled by defining SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    seg7_scan_driver_if.slave    bus,
    output logic [7:0]           digit_en_o,
    output logic [6:0]           seg_o,
    output logic                 dp_o
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        DWELL,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   value_q;
    logic [7:0]    mask_q;
    logic [7:0]    en_q, en_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nibble;
    logic          lz_blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign nibble = value_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    // Slot i (i >= 1) goes dark when nibbles i..7 are all zero.
    always_comb begin
        lz_blank = (idx_q != 3'd0) && ((value_q >> {idx_q, 2'b00}) == 32'd0);
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        en_d    = '1;
        seg_d   = '1;
        case (state_q)
            DWELL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mask_q[idx_q] && !lz_blank) begin
                    en_d  = ~(8'b1 << idx_q);
                    seg_d = hex_decode(nibble);
                end
            end
            BLANK: begin
                idx_d   = idx_q + 3'd1;
                state_d = DWELL;
            end
            default: state_d = DWELL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DWELL;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= '1;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
            mask_q  <= '1;
        end else begin
            if (bus.val_we_i)  value_q <= bus.wdata_i;
            if (bus.mask_we_i) mask_q  <= bus.wdata_i[7:0];
        end
    end

    assign bus.value_o = value_q;
    assign bus.mask_o  = mask_q;
    assign digit_en_o  = en_q;
    assign seg_o       = seg_q;
    assign dp_o        = 1'b1;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-position reference model.
module tb_seg7_scan_driver;
    localparam int N     = 4;
    localparam int SLOT  = N + 1;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] digit_en;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver_if bus_if ();

    seg7_scan_driver #(.SCAN_DIV(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus_if),
        .digit_en_o (digit_en),
        .seg_o      (seg),
        .dp_o       (dp)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: registers as the CPU sees them, and cycles elapsed since reset.
    logic [31:0] m_value;
    logic [7:0]  m_mask;
    int unsigned m_t;
    logic [6:0]  glyph [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
        end
    endtask

    task automatic model_out(output logic [7:0] en, output logic [6:0] sg);
        int unsigned p, slot, ph;
        logic lz;
        p    = m_t % FRAME;
        slot = p / SLOT;
        ph   = p % SLOT;
        lz   = 1'b0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        lz = (slot >= 1) && ((m_value >> (4 * slot)) == 32'd0);
`endif
        en = 8'hFF;
        sg = 7'h7F;
        if (ph < N && m_mask[slot] && !lz) begin
            en = ~(8'h01 << slot);
            sg = glyph[(m_value >> (4 * slot)) & 32'hF];
        end
    endtask

    task automatic cycle(input logic r, input logic vwe, input logic mwe, input logic [31:0] wd);
        logic [7:0] exp_en;
        logic [6:0] exp_seg;
        rst              = r;
        bus_if.val_we_i  = vwe;
        bus_if.mask_we_i = mwe;
        bus_if.wdata_i   = wd;
        if (r) begin
            exp_en  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            model_out(exp_en, exp_seg);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_value = 32'd0;
            m_mask  = 8'hFF;
            m_t     = 0;
        end else begin
            m_t++;
            if (vwe) m_value = wd;
            if (mwe) m_mask  = wd[7:0];
        end
        check("digit_en", {24'd0, digit_en}, {24'd0, exp_en});
        check("seg", {25'd0, seg}, {25'd0, exp_seg});
        check("dp", {31'd0, dp}, 32'd1);
        check("value_rb", bus_if.value_o, m_value);
        check("mask_rb", {24'd0, bus_if.mask_o}, {24'd0, m_mask});
        check("onehot", {31'd0, ($countones(~digit_en) <= 1)}, 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        m_value = 32'd0;
        m_mask  = 8'hFF;
        m_t     = 0;
        rst = 1'b1;
        bus_if.val_we_i  = 1'b0;
        bus_if.mask_we_i = 1'b0;
        bus_if.wdata_i   = 32'd0;

        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        idle(FRAME);

        cycle(1'b0, 1'b1, 1'b0, 32'h1234_5678);
        idle(2 * FRAME);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_000F);
        idle(FRAME);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_00FF);

        // Land a write mid-dwell on digit 2, then a reset while digit 5 is lit.
        while ((m_t % FRAME) != 2 * SLOT + 1) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        idle(2);
        while ((m_t % FRAME) != 5 * SLOT + 2) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        idle(FRAME);

        cycle(1'b0, 1'b1, 1'b0, 32'h0000_00A0);
        idle(FRAME);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0000);
        idle(FRAME);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_00FF);

        for (int unsigned i = 0; i < 2000; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 299) == 0)
                cycle(1'b1, 1'($urandom), 1'($urandom), v);
            else if ($urandom_range(0, 15) == 0)
                cycle(1'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0), v | (32'($urandom) & 32'hFF));
            else
                cycle(1'b0, 1'b0, 1'b0, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
